// File: rtl/calc_pkg.sv
// calc_pkg: shared constants and state type for the calc result serializer.
// LAST beat index depends on CALC_SER_CHKSUM_EN (adds the XOR checksum beat).
package calc_pkg;
  localparam int NUM_RESULTS = 6;
  localparam int IDX_W = 3;
  localparam logic [IDX_W-1:0] IDX_S1 = 3'd0;
  localparam logic [IDX_W-1:0] IDX_S2 = 3'd1;
  localparam logic [IDX_W-1:0] IDX_S3 = 3'd2;
  localparam logic [IDX_W-1:0] IDX_S4 = 3'd3;
  localparam logic [IDX_W-1:0] IDX_S5 = 3'd4;
  localparam logic [IDX_W-1:0] IDX_S6 = 3'd5;
  localparam logic [IDX_W-1:0] IDX_CHK = 3'd6;
`ifdef CALC_SER_CHKSUM_EN
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_CHK;
`else
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_S6;
`endif
  typedef enum logic {IDLE, SEND} state_t;
endpackage

// File: rtl/calc_ser_chksum.sv
// calc_ser_chksum: BW-bit XOR reduction of the six captured result words.
module calc_ser_chksum
  import calc_pkg::*;
#(
  parameter int BW = 8
) (
  input  logic [NUM_RESULTS*BW-1:0] words,
  output logic [BW-1:0]             chk
);
  always_comb begin
    chk = '0;
    for (int i = 0; i < NUM_RESULTS; i++) chk = chk ^ words[i*BW +: BW];
  end
endmodule

// File: rtl/calc_result_serializer.sv
// calc_result_serializer: captures a six-word result bundle and streams it one word per beat.
// Define CALC_SER_CHKSUM_EN to append a seventh XOR-checksum beat (idx 6).
module calc_result_serializer
  import calc_pkg::*;
#(
  parameter int BW    = 8,
  parameter int CNT_W = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [NUM_RESULTS*BW-1:0] in_bus,
  input  logic                      in_div0,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [BW-1:0]             out_data,
  output logic [IDX_W-1:0]          out_idx,
  output logic                      out_last,
  output logic                      out_err,
  output logic [CNT_W-1:0]          bundle_cnt
);
  state_t                    state_q, state_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [NUM_RESULTS*BW-1:0] bus_q, bus_d;
  logic                      div0_q, div0_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic                      send, at_last, beat, capture;
  logic [BW-1:0]             word;
  assign send    = state_q == SEND;
  assign at_last = send && idx_q == IDX_LAST;
  assign beat    = send && out_ready;
  // A new bundle may only enter when the last beat of the current one leaves.
  assign in_ready = !rst && (!send || (at_last && out_ready));
  assign capture  = in_valid && in_ready;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      bus_q   <= '0;
      div0_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      bus_q   <= bus_d;
      div0_q  <= div0_d;
      cnt_q   <= cnt_d;
    end
  end
  always_comb begin
    state_d = capture ? SEND : (beat && at_last) ? IDLE : state_q;
  end
  always_comb begin
    bus_d  = capture ? in_bus : bus_q;
    div0_d = capture ? in_div0 : div0_q;
    idx_d  = capture ? '0 : (beat && !at_last) ? idx_q + 1'b1 : idx_q;
    cnt_d  = (beat && at_last) ? cnt_q + 1'b1 : cnt_q;
  end
`ifdef CALC_SER_CHKSUM_EN
  logic [BW-1:0] chk;
  calc_ser_chksum #(.BW(BW)) u_chksum (.words(bus_q), .chk(chk));
`endif
  always_comb begin
    word = '0;
    for (int i = 0; i < NUM_RESULTS; i++)
      if (idx_q == i[IDX_W-1:0]) word = bus_q[i*BW +: BW];
`ifdef CALC_SER_CHKSUM_EN
    if (idx_q == IDX_CHK) word = chk;
`endif
  end
  always_comb begin
    out_valid  = send;
    out_data   = send ? word : '0;
    out_idx    = send ? idx_q : '0;
    out_last   = at_last;
    out_err    = send && idx_q == IDX_S3 && div0_q;
    bundle_cnt = cnt_q;
  end
endmodule

// File: tb/tb_calc_result_serializer.sv
// tb_calc_result_serializer: directed checks of the result serializer (a=7,b=3,c=2,d=5 bundle).
// A second instance with CNT_W=2 exercises the bundle counter wrap.
module tb_calc_result_serializer;
`ifdef CALC_SER_CHKSUM_EN
  localparam int LAST = 6;
`else
  localparam int LAST = 5;
`endif
  localparam logic [47:0] BUS = {8'd32, 8'd4, 8'd28, 8'd6, 8'd21, 8'd10};
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_div0 = 1'b0;
  logic        out_ready = 1'b1;
  logic [47:0] in_bus = '0;
  logic        in_ready, out_valid, out_last, out_err;
  logic [7:0]  out_data;
  logic [2:0]  out_idx;
  logic [15:0] bundle_cnt;
  logic        w_in_ready, w_out_valid, w_out_last, w_out_err;
  logic [7:0]  w_out_data;
  logic [2:0]  w_out_idx;
  logic [1:0]  w_cnt;
  logic [7:0]  s [7] = '{8'd10, 8'd21, 8'd6, 8'd28, 8'd4, 8'd32, 8'h21};
  int          checks = 0;
  int          errors = 0;
  int          exp_cnt = 0;
  always #5 clk = ~clk;
  calc_result_serializer #(.BW(8), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_bus(in_bus),
    .in_div0(in_div0), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_idx(out_idx), .out_last(out_last), .out_err(out_err), .bundle_cnt(bundle_cnt)
  );
  calc_result_serializer #(.BW(8), .CNT_W(2)) u_wrap (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(w_in_ready), .in_bus(in_bus),
    .in_div0(in_div0), .out_valid(w_out_valid), .out_ready(out_ready), .out_data(w_out_data),
    .out_idx(w_out_idx), .out_last(w_out_last), .out_err(w_out_err), .bundle_cnt(w_cnt)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic accept(input bit div0, input bit keep);
    int n = 0;
    in_bus = BUS;
    in_div0 = div0;
    in_valid = 1'b1;
    #1;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    check("accept_wait", n < 20, 1);
    tick();
    if (!keep) in_valid = 1'b0;
  endtask
  task automatic run_beats(input bit div0, input int stall_idx, input int stall_n);
    for (int k = 0; k <= LAST; k++) begin
      if (k == stall_idx) begin
        out_ready = 1'b0;
        in_bus = '1;
        #1;
        for (int j = 0; j < stall_n; j++) begin
          check("stall_data", out_data, s[k]);
          check("stall_idx", out_idx, k);
          check("stall_in_ready", in_ready, 0);
          tick();
        end
        out_ready = 1'b1;
        in_bus = BUS;
      end
      check("beat_valid", out_valid, 1);
      check("beat_data", out_data, s[k]);
      check("beat_idx", out_idx, k);
      check("beat_last", out_last, k == LAST);
      check("beat_err", out_err, div0 && k == 2);
      tick();
    end
  endtask
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    tick();
    tick();
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_idx", out_idx, 0);
    check("rst_last", out_last, 0);
    check("rst_err", out_err, 0);
    check("rst_cnt", bundle_cnt, 0);
    check("rst_in_ready", in_ready, 0);
    rst = 1'b0;
    #1;
    check("idle_in_ready", in_ready, 1);
    // 1: single bundle
    accept(0, 0);
    run_beats(0, -1, 0);
    exp_cnt++;
    check("t1_idle", out_valid, 0);
    check("t1_cnt", bundle_cnt, exp_cnt);
    // 2: backpressure on beat 3
    accept(0, 0);
    run_beats(0, 3, 4);
    exp_cnt++;
    check("t2_idle", out_valid, 0);
    check("t2_cnt", bundle_cnt, exp_cnt);
    // 3: back-to-back bundles
    accept(0, 1);
    run_beats(0, -1, 0);
    in_valid = 1'b0;
    run_beats(0, -1, 0);
    exp_cnt += 2;
    check("t3_idle", out_valid, 0);
    check("t3_cnt", bundle_cnt, exp_cnt);
    // 4: divide-by-zero flag
    accept(1, 0);
    run_beats(1, -1, 0);
    exp_cnt++;
    check("t4_cnt", bundle_cnt, exp_cnt);
    // 5: reset mid-bundle
    accept(0, 0);
    tick();
    tick();
    check("t5_idx_before", out_idx, 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("t5_valid", out_valid, 0);
    check("t5_cnt", bundle_cnt, 0);
    check("t5_in_ready", in_ready, 1);
    accept(0, 0);
    run_beats(0, -1, 0);
    check("t5_cnt_after", bundle_cnt, 1);
    for (int b = 0; b < 2; b++) begin
      accept(0, 0);
      run_beats(0, -1, 0);
    end
    check("wrap_cnt3", w_cnt, 3);
    accept(0, 0);
    run_beats(0, -1, 0);
    check("wrap_cnt0", w_cnt, 0);
    check("main_cnt4", bundle_cnt, 4);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
